piso_serializer: RTL and testbench

Parametrised parallel-in/serial-out shifter for the UART TX datapath and other serial links in the system. It loads a word of up to WIDTH bits, shifts it out one bit per enabled cycle, LSB- or MSB-first, with a per-frame length. It signals completion with a one-cycle done pulse. It sits between the TX frame FSM, which drives LOAD and ser_en, and the output bit mux. It can optionally produce the frame parity bit.

---
 rtl/piso_serializer.sv | 112 +++++++++++
 tb/tb_piso_serializer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter with per-frame length and done pulse.
// Optional frame parity output enabled by defining SER_PARITY_EN.
module piso_serializer #(
  parameter int   WIDTH     = 8,
  parameter int   MSB_FIRST = 0,
  parameter logic IDLE_LVL  = 1'b1,
  parameter int   PAR_ODD   = 0,
  parameter int   LEN_W     = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic [LEN_W-1:0] LEN,
  input  logic             LOAD,
  input  logic             ser_en,
  output logic             ser_data,
  output logic             busy,
  output logic             ser_done,
  output logic             par_bit
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  localparam bit MSB = (MSB_FIRST != 0);
  localparam logic [LEN_W-1:0] FULL = LEN_W'(WIDTH);

  logic             state;
  logic [WIDTH-1:0] shift_reg;
  logic [LEN_W-1:0] cnt;
  logic             done_q;

  logic [LEN_W-1:0] eff_len;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] field;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] shifted;
  logic             take;

  assign eff_len = (LEN == '0 || LEN > FULL) ? FULL : LEN;
  assign mask    = ~({WIDTH{1'b1}} << eff_len);
  assign field   = P_DATA & mask;

  // MSB-first frames are left-aligned so bit L-1 sits at the top.
  assign load_val = MSB ? (field << (FULL - eff_len)) : field;

  assign shifted = MSB ? {shift_reg[WIDTH-2:0], 1'b0}
                       : {1'b0, shift_reg[WIDTH-1:1]};

  assign take = (state == ST_IDLE) && LOAD;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      cnt       <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (LOAD) begin
            shift_reg <= load_val;
            cnt       <= eff_len;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (ser_en) begin
            shift_reg <= shifted;
            cnt       <= cnt - 1'b1;
            if (cnt == LEN_W'(1)) begin
              state  <= ST_IDLE;
              done_q <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = (state == ST_SHIFT);
  assign ser_done = done_q;

  always_comb begin
    ser_data = IDLE_LVL;
    if (state == ST_SHIFT)
      ser_data = MSB ? shift_reg[WIDTH-1] : shift_reg[0];
  end

`ifdef SER_PARITY_EN
  localparam logic PAR_INV = (PAR_ODD != 0);

  logic par;

  always_ff @(posedge CLK) begin
    if (RST)
      par <= 1'b0;
    else if (take)
      par <= (^field) ^ PAR_INV;
  end

  assign par_bit = par;
`else
  logic unused_par;

  assign unused_par = (PAR_ODD != 0) ^ take;
  assign par_bit    = 1'b0;
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: LSB- and MSB-first instances
// driven in lockstep, checked with immediate assertions.
module tb_piso_serializer;

`ifdef SER_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic [3:0] LEN;
  logic       LOAD;
  logic       ser_en;

  logic sd_l, busy_l, done_l, par_l;
  logic sd_m, busy_m, done_m, par_m;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  piso_serializer #(
    .WIDTH(8), .MSB_FIRST(0), .IDLE_LVL(1'b1), .PAR_ODD(0)
  ) u_lsb (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .LEN(LEN),
    .LOAD(LOAD), .ser_en(ser_en), .ser_data(sd_l),
    .busy(busy_l), .ser_done(done_l), .par_bit(par_l)
  );

  piso_serializer #(
    .WIDTH(8), .MSB_FIRST(1), .IDLE_LVL(1'b1), .PAR_ODD(0)
  ) u_msb (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .LEN(LEN),
    .LOAD(LOAD), .ser_en(ser_en), .ser_data(sd_m),
    .busy(busy_m), .ser_done(done_m), .par_bit(par_m)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic done);
    chk({tag, "_busy_l"}, busy_l, 1'b0);
    chk({tag, "_busy_m"}, busy_m, 1'b0);
    chk({tag, "_done_l"}, done_l, done);
    chk({tag, "_done_m"}, done_m, done);
    chk({tag, "_sd_l"}, sd_l, 1'b1);
    chk({tag, "_sd_m"}, sd_m, 1'b1);
  endtask

  // Expected sequences are written in transmit order, left to right.
  task automatic send(input string tag, input logic [7:0] d,
                      input logic [3:0] len, input int l,
                      input logic [7:0] el, input logic [7:0] em,
                      input logic ep);
    P_DATA = d;
    LEN    = len;
    LOAD   = 1'b1;
    ser_en = 1'b1;
    tick();
    LOAD = 1'b0;
    chk({tag, "_par_l"}, par_l, ep & PAR_ON);
    for (int k = 0; k < l; k++) begin
      chk({tag, "_busy"}, busy_l & busy_m, 1'b1);
      chk({tag, "_dn"}, done_l | done_m, 1'b0);
      chk({tag, "_bit_l"}, sd_l, el[7-k]);
      chk({tag, "_bit_m"}, sd_m, em[7-k]);
      tick();
    end
    chk_idle({tag, "_end"}, 1'b1);
    chk({tag, "_par_hold"}, par_m, ep & PAR_ON);
  endtask

  initial begin
    RST    = 1'b1;
    LOAD   = 1'b1;
    P_DATA = 8'hA5;
    LEN    = 4'd8;
    ser_en = 1'b1;
    tick();
    tick();
    chk_idle("rst", 1'b0);
    chk("rst_par", par_l | par_m, 1'b0);
    RST  = 1'b0;
    LOAD = 1'b0;
    tick();
    chk_idle("rst_noload", 1'b0);

    send("a5", 8'hA5, 4'd8, 8, 8'b10100101, 8'b10100101, 1'b0);
    LOAD = 1'b0;
    tick();
    chk_idle("a5_post", 1'b0);

    send("f6", 8'hF6, 4'd5, 5, 8'b01101000, 8'b10110000, 1'b1);
    tick();
    chk_idle("f6_post", 1'b0);

    send("l1", 8'h01, 4'd1, 1, 8'b10000000, 8'b10000000, 1'b1);
    tick();
    chk_idle("l1_post", 1'b0);

    send("l15", 8'h1D, 4'd15, 8, 8'b10111000, 8'b00011101, 1'b0);
    tick();
    chk_idle("l15_post", 1'b0);

    // One enable in four, with a stray LOAD mid-frame.
    P_DATA = 8'h1D;
    LEN    = 4'd8;
    LOAD   = 1'b1;
    ser_en = 1'b0;
    tick();
    LOAD = 1'b0;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 4; j++) begin
        chk("stall_busy", busy_l & busy_m, 1'b1);
        chk("stall_dn", done_l | done_m, 1'b0);
        chk("stall_l", sd_l, 8'b10111000 >> (7 - k) & 8'd1);
        chk("stall_m", sd_m, 8'b00011101 >> (7 - k) & 8'd1);
        ser_en = (j == 3);
        LOAD   = (k == 2 && j == 1);
        P_DATA = LOAD ? 8'h00 : 8'h1D;
        tick();
      end
    end
    ser_en = 1'b0;
    LOAD   = 1'b0;
    chk_idle("stall_end", 1'b1);
    tick();
    chk_idle("stall_post", 1'b0);

    // Reset while bit 3 is on the line.
    P_DATA = 8'h1D;
    LEN    = 4'd8;
    LOAD   = 1'b1;
    ser_en = 1'b1;
    tick();
    LOAD = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_bit3_l", sd_l, 1'b1);
    chk("mid_bit3_m", sd_m, 1'b1);
    chk("mid_busy", busy_l & busy_m, 1'b1);
    RST = 1'b1;
    tick();
    chk_idle("mid_rst", 1'b0);
    chk("mid_par", par_l | par_m, 1'b0);
    RST = 1'b0;
    tick();
    chk_idle("mid_post", 1'b0);

    // Back-to-back: second LOAD lands in the done cycle.
    send("b2b1", 8'h07, 4'd0, 8, 8'b11100000, 8'b00000111, 1'b1);
    send("b2b2", 8'h03, 4'd0, 8, 8'b11000000, 8'b00000011, 1'b0);
    tick();
    chk_idle("b2b_post", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
